// File: rtl/rr_output_arbiter_if.sv
// Request/grant bundle between the mesh input ports and the per-output arbiter.
// The tail-flit release strobe is named release_req because "release" is reserved in SystemVerilog.
interface rr_output_arbiter_if #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2
);
  logic [INPUTS-1:0]                req_valid;
  logic [INPUTS*REQUEST_WIDTH-1:0]  req_dest;
  logic [INPUTS-1:0]                release_req;
  logic [INPUTS-1:0]                grant;
  logic [INPUTS-1:0]                granted;
  logic [OUTPUTS*REQUEST_WIDTH-1:0] route_select;
  logic [OUTPUTS-1:0]               output_busy;

  modport master (
    output req_valid, req_dest, release_req,
    input  grant, granted, route_select, output_busy
  );

  modport slave (
    input  req_valid, req_dest, release_req,
    output grant, granted, route_select, output_busy
  );
endinterface

// File: rtl/rr_output_arbiter.sv
// Per-output round-robin arbiter with path locking for the 4x4 mesh switch crossbar.
// Each output is FREE or LOCKED; a lock is held until its owner raises release_req.
module rr_output_arbiter #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  rr_output_arbiter_if.slave bus
);
  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} state_t;
  typedef logic [REQUEST_WIDTH-1:0] idx_t;

  state_t            state_q [OUTPUTS];
  state_t            state_d [OUTPUTS];
  idx_t              owner_q [OUTPUTS];
  idx_t              owner_d [OUTPUTS];
  idx_t              ptr_q   [OUTPUTS];
  idx_t              ptr_d   [OUTPUTS];
  logic [INPUTS-1:0] eligible [OUTPUTS];
  logic [INPUTS-1:0] grant_q;
  logic [INPUTS-1:0] grant_d;
  logic [INPUTS-1:0] granted_w;
  logic              found   [OUTPUTS];
  int                win     [OUTPUTS];
  int                best    [OUTPUTS];

  always_comb begin
    granted_w = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      if (state_q[o] == LOCKED) granted_w[owner_q[o]] = 1'b1;
    end
  end

  // Destinations outside the output range never match any o, so they are dropped here.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      eligible[o] = '0;
      for (int j = 0; j < INPUTS; j++) begin
        eligible[o][j] = bus.req_valid[j] && !granted_w[j] &&
                         (bus.req_dest[j*REQUEST_WIDTH +: REQUEST_WIDTH] == idx_t'(o));
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found[o]   = 1'b0;
      win[o]     = 0;
      best[o]    = INPUTS;
      case (state_q[o])
        FREE: begin
          // Winner is the eligible input at the smallest rotating distance from ptr.
          for (int j = 0; j < INPUTS; j++) begin
            if (eligible[o][j] && (((j - int'(ptr_q[o]) + INPUTS) % INPUTS) < best[o])) begin
              best[o] = (j - int'(ptr_q[o]) + INPUTS) % INPUTS;
              win[o]  = j;
            end
          end
          found[o] = (best[o] < INPUTS);
          if (found[o]) begin
            state_d[o] = LOCKED;
            owner_d[o] = idx_t'(win[o]);
            ptr_d[o]   = idx_t'((win[o] + 1) % INPUTS);
            for (int j = 0; j < INPUTS; j++) begin
              if (j == win[o]) grant_d[j] = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (bus.release_req[owner_q[o]]) state_d[o] = FREE;
        end
        default: state_d[o] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= FREE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      grant_q <= '0;
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      grant_q <= grant_d;
    end
  end

  always_comb begin
    bus.route_select = '0;
    bus.output_busy  = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      bus.route_select[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner_q[o];
      bus.output_busy[o] = (state_q[o] == LOCKED);
    end
  end

  assign bus.grant   = grant_q;
  assign bus.granted = granted_w;
endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter: a vector table plus hand-written lock/rotation/reset sequences.
// A second instance with three outputs exercises out-of-range destinations.
module tb_rr_output_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  rr_output_arbiter_if #(.INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(2)) bus ();
  rr_output_arbiter_if #(.INPUTS(4), .OUTPUTS(3), .REQUEST_WIDTH(2)) bus3 ();

  rr_output_arbiter #(.INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  rr_output_arbiter #(.INPUTS(4), .OUTPUTS(3), .REQUEST_WIDTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  typedef struct {
    logic [3:0] valid;
    logic [7:0] dest;
    logic [3:0] rel;
    logic [3:0] expGrant;
    logic [3:0] expGranted;
    logic [3:0] expBusy;
    logic [7:0] expRsel;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] dest, input logic [3:0] rel);
    bus.req_valid   = valid;
    bus.req_dest    = dest;
    bus.release_req = rel;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 8'h00, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] valid;
    int         order [3];
    int         waited;

    vecs[0]  = '{4'b0001, 8'h02, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 8'h00};
    vecs[1]  = '{4'b0001, 8'h02, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 8'h00};
    vecs[2]  = '{4'b0000, 8'h02, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'h00};
    vecs[3]  = '{4'b1111, 8'h1B, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 8'h1B};
    vecs[4]  = '{4'b0000, 8'h1B, 4'b0101, 4'b0000, 4'b1010, 4'b0101, 8'h1B};
    vecs[5]  = '{4'b0000, 8'h1B, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 8'h1B};
    vecs[6]  = '{4'b1010, 8'h00, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 8'h19};
    vecs[7]  = '{4'b1010, 8'h00, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 8'h19};
    vecs[8]  = '{4'b1010, 8'h00, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 8'h1B};
    vecs[9]  = '{4'b0000, 8'h00, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 8'h1B};
    vecs[10] = '{4'b0000, 8'h00, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8'h1B};
    vecs[11] = '{4'b0100, 8'h30, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 8'h9B};
    vecs[12] = '{4'b0000, 8'h30, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'h9B};

    bus3.req_valid   = 4'b0000;
    bus3.req_dest    = 8'h00;
    bus3.release_req = 4'b0000;

    doReset();
    checkOutput("reset grant", 16'(bus.grant), 16'h0);
    checkOutput("reset granted", 16'(bus.granted), 16'h0);
    checkOutput("reset busy", 16'(bus.output_busy), 16'h0);
    checkOutput("reset rsel", 16'(bus.route_select), 16'h0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].dest, vecs[i].rel);
      tick();
      checkOutput($sformatf("vec%0d grant", i), 16'(bus.grant), 16'(vecs[i].expGrant));
      checkOutput($sformatf("vec%0d granted", i), 16'(bus.granted), 16'(vecs[i].expGranted));
      checkOutput($sformatf("vec%0d busy", i), 16'(bus.output_busy), 16'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d rsel", i), 16'(bus.route_select), 16'(vecs[i].expRsel));
    end

    // Three inputs contend for output 1; each owner releases three cycles after its grant.
    doReset();
    order = '{0, 1, 3};
    valid = 4'b1011;
    applyStimulus(valid, 8'h45, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      do begin
        tick();
        bus.release_req = 4'b0000;
        waited++;
      end while (bus.grant == 4'b0000 && waited < 10);
      checkOutput($sformatf("rr%0d latency", k), 16'(waited), (k == 0) ? 16'd1 : 16'd2);
      checkOutput($sformatf("rr%0d grant", k), 16'(bus.grant), 16'(1 << order[k]));
      checkOutput($sformatf("rr%0d rsel1", k), 16'(bus.route_select[3:2]), 16'(order[k]));
      valid[order[k]] = 1'b0;
      bus.req_valid = valid;
      tick();
      tick();
      tick();
      bus.release_req = 4'(1 << order[k]);
    end
    tick();
    bus.release_req = 4'b0000;
    tick();
    checkOutput("rr final busy", 16'(bus.output_busy), 16'h0);

    // Non-owner release is ignored, then a reset mid-lock clears everything.
    doReset();
    applyStimulus(4'b1000, 8'h80, 4'b0000);
    tick();
    checkOutput("lock grant", 16'(bus.grant), 16'b1000);
    checkOutput("lock busy", 16'(bus.output_busy), 16'b0100);
    applyStimulus(4'b0000, 8'h80, 4'b0001);
    tick();
    checkOutput("foreign release busy", 16'(bus.output_busy), 16'b0100);
    checkOutput("foreign release granted", 16'(bus.granted), 16'b1000);
    applyStimulus(4'b1000, 8'h80, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset grant", 16'(bus.grant), 16'h0);
    checkOutput("midreset granted", 16'(bus.granted), 16'h0);
    checkOutput("midreset busy", 16'(bus.output_busy), 16'h0);
    checkOutput("midreset rsel", 16'(bus.route_select), 16'h0);
    tick();
    checkOutput("regrant grant", 16'(bus.grant), 16'b1000);
    checkOutput("regrant rsel2", 16'(bus.route_select[5:4]), 16'd3);

    // Three-output instance: destination 3 is out of range and must never lock anything.
    bus3.req_valid = 4'b0010;
    bus3.req_dest  = 8'h0C;
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("oob%0d grant", c), 16'(bus3.grant), 16'h0);
      checkOutput($sformatf("oob%0d busy", c), 16'(bus3.output_busy), 16'h0);
    end
    bus3.req_dest = 8'h08;
    tick();
    checkOutput("inrange grant", 16'(bus3.grant), 16'b0010);
    checkOutput("inrange busy", 16'(bus3.output_busy), 16'b100);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
